// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked accumulator.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } acc_state_e;

  function automatic int unsigned nchunk(input int unsigned acc_w, input int unsigned width);
    return acc_w / width;
  endfunction

endpackage

// File: rtl/add_slice.sv
// WIDTH-bit combinational ripple-carry adder slice.
module add_slice #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/chunked_accumulator.sv
// Running-sum stage: one WIDTH-bit adder slice reused over ACC_W/WIDTH cycles,
// LSB chunk first, carry held in a register between chunks.
module chunked_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int unsigned NCHUNK = nchunk(ACC_W, WIDTH);
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned BASE_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((ACC_W % WIDTH) != 0) begin : g_bad_width
    $error("chunked_accumulator: ACC_W must be a multiple of WIDTH");
  end

  acc_state_e        r_state;
  acc_state_e        w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_work;
  logic [ACC_W-1:0]  r_op;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;
  logic              r_ovf;
  logic              r_out_valid;

  logic              w_last;
  logic [BASE_W-1:0] w_base;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-1:0]  w_s;
  logic              w_cout;
  logic [ACC_W-1:0]  w_work_upd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; clear in IDLE blocks the input handshake
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (!clear && in_valid) w_state_nxt = ADD;
      ADD: begin
        w_last = (r_idx == LAST_IDX);
        if (w_last) w_state_nxt = RESP;
      end
      RESP: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the current chunk of working sum and operand
  always_comb begin
    w_base     = BASE_W'(r_idx) * BASE_W'(WIDTH);
    w_a        = r_work[w_base +: WIDTH];
    w_b        = r_op[w_base +: WIDTH];
    w_work_upd = r_work;
    w_work_upd[w_base +: WIDTH] = w_s;
  end

  add_slice #(.WIDTH(WIDTH)) u_slice (
    .a    (w_a),
    .b    (w_b),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Datapath; the committed sum only changes on clear or on the last chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_work      <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == RESP);
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else if (in_valid) begin
            r_op    <= ACC_W'(in_data);
            r_work  <= r_acc;
            r_carry <= 1'b0;
            r_idx   <= '0;
          end
        end
        ADD: begin
          r_work  <= w_work_upd;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_acc <= w_work_upd;
            r_ovf <= r_ovf | w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !clear;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;

endmodule
